pattern_matcher_n: RTL and testbench
====================================

PATTERN_MATCHER_N -- requirements
Module: pattern_matcher_n

Interface
REQ-001 Parameter: PAT_W, default 8, pattern width in bits; legal range 2..16.
REQ-002 Parameter: CNT_W, default 8, match-counter width in bits; legal range 1..16.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-low.
REQ-005 Port: data_in  input  1  serial data bit, sampled only when input_valid=1.
REQ-006 Port: input_valid  input  1  qualifies data_in for the current cycle.
REQ-007 Port: pattern  input  PAT_W  target pattern; bit PAT_W-1 is the oldest bit in time.
REQ-008 Port: mask  input  PAT_W  per-bit compare enable (1=compare, 0=don't care).
REQ-009 Port: load_pattern  input  1  captures pattern and mask, then arms the detector.
REQ-010 Port: overlap_en  input  1  1=overlapping matches allowed, 0=non-overlapping.
REQ-011 Port: clear_count  input  1  synchronous clear of match_count.
REQ-012 Port: match  output  1  registered, one-cycle pulse per detected match.
REQ-013 Port: match_count  output  CNT_W  saturating count of matches.
REQ-014 Port: armed  output  1  high when the state is FILL or HUNT.

Function
REQ-015 FSM states: IDLE (unarmed), FILL (fewer than PAT_W valid bits held), HUNT (history full, comparing).
REQ-016 Transitions: IDLE->FILL on load_pattern; FILL->HUNT when fill count reaches PAT_W; HUNT->FILL after a match when overlap_en=0; any armed state->FILL on load_pattern.
REQ-017 load_pattern in any state: capture pattern/mask, clear history and fill count; that cycle's data bit is discarded.
REQ-018 Valid beat in FILL/HUNT: history <= {history[PAT_W-2:0], data_in}; fill count increments, saturating at PAT_W.
REQ-019 input_valid=0: history, fill count and state hold; gaps do not break a partial sequence.
REQ-020 Match condition (HUNT, or the FILL beat completing PAT_W bits): ((next history XOR stored pattern) AND stored mask) == 0 on a valid beat.
REQ-021 Latency: match is high in the cycle after the rising edge that accepted the final matching bit, for exactly one cycle.
REQ-022 overlap_en=0: on a match, fill count clears; the next match needs PAT_W fresh valid bits.
REQ-023 overlap_en=1: the history is retained; consecutive valid beats may match back-to-back.
REQ-024 mask all-zero: every valid beat matches once the history is full.
REQ-025 match_count increments by 1 per match and holds at 2^CNT_W-1 (no wrap).
REQ-026 clear_count together with a match in the same cycle: clear wins, so the count becomes 0.
REQ-027 overlap_en is sampled per beat; changing it mid-stream takes effect on the next valid beat.
REQ-028 No data is accepted in IDLE; match stays 0.

Reset
REQ-029 rst=0 asynchronously forces: state IDLE, history 0, fill count 0, stored pattern/mask 0, match 0, match_count 0, armed 0.
REQ-030 Reset mid-stream discards the partial sequence; re-arming requires load_pattern after release.

Structure
REQ-031 Package pattern_matcher_pkg holds the FSM state enum (IDLE, FILL, HUNT) and the default PAT_W/CNT_W constants.
REQ-032 One sub-module, sat_counter (CNT_W, inc, clr, clr priority), implements match_count; everything else stays in pattern_matcher_n.

Verification
REQ-033 PAT_W=8, pattern 8'hA5, mask 8'hFF, overlap_en=0; load, then stream 10100101 -> match pulses once, 1 cycle after the 8th bit; match_count=1.
REQ-034 Pattern 8'hAA, overlap_en=1; stream 1010101010 -> matches after bits 8 and 10 (count=2); with overlap_en=0 -> only one match.
REQ-035 Pattern 8'hA5, mask 8'hF0; stream 1010 followed by 0000 -> match (low nibble ignored).
REQ-036 Stream 1010 0101 with input_valid low for 3 cycles between the nibbles -> single match.
REQ-037 CNT_W=2; four matches -> count sequence 1,2,3,3; clear_count asserted with the 5th match -> count 0.
REQ-038 Assert rst after 5 bits of 8'hA5, release, send the remaining 3 bits -> no match, armed=0; after a reload and a full stream -> match.

Source files
------------

// File: rtl/pattern_matcher_pkg.sv
// Shared types and default sizes for the serial pattern matcher.
package pattern_matcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // unarmed, serial data ignored
        FILL = 2'd1,   // fewer than PAT_W valid bits held since arming/last match
        HUNT = 2'd2    // history full, comparing on every valid beat
    } state_e;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/pattern_matcher_n_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count up to all-ones and hold there; clear takes priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pattern_matcher_n.sv
// Serial masked pattern detector with overlap control and a saturating
// match counter. History shifts in at the LSB, so bit PAT_W-1 is oldest.
module pattern_matcher_n
    import pattern_matcher_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             input_valid,
    input  logic [PAT_W-1:0] pattern,
    input  logic [PAT_W-1:0] mask,
    input  logic             load_pattern,
    input  logic             overlap_en,
    input  logic             clear_count,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam int                FC_W     = $clog2(PAT_W + 1);
    localparam logic [FC_W-1:0]   FILL_MAX = FC_W'(PAT_W);

    state_e           r_state, w_state_nxt;
    logic [PAT_W-1:0] r_hist, r_pat, r_mask, w_hist_shift;
    logic [FC_W-1:0]  r_fill, w_fill_nxt, w_fill_inc;
    logic             r_match, w_beat, w_hit;

    // Beat qualification and match decision on the would-be next history.
    // A load cycle never accepts its data bit.
    always_comb begin
        w_beat       = input_valid && (r_state != IDLE) && !load_pattern;
        w_hist_shift = {r_hist[PAT_W-2:0], data_in};
        w_fill_inc   = (r_fill == FILL_MAX) ? r_fill : r_fill + FC_W'(1);
        w_hit        = w_beat && (w_fill_inc == FILL_MAX) &&
                       (((w_hist_shift ^ r_pat) & r_mask) == '0);
    end

    // Next-state and fill-count logic.
    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        case (r_state)
            IDLE: begin
                if (load_pattern) begin
                    w_state_nxt = FILL;
                    w_fill_nxt  = '0;
                end
            end
            FILL, HUNT: begin
                if (load_pattern) begin
                    w_state_nxt = FILL;
                    w_fill_nxt  = '0;
                end else if (w_beat) begin
                    if (w_hit && !overlap_en) begin
                        // Non-overlapping: next match needs PAT_W fresh bits.
                        w_state_nxt = FILL;
                        w_fill_nxt  = '0;
                    end else begin
                        w_fill_nxt  = w_fill_inc;
                        w_state_nxt = (w_fill_inc == FILL_MAX) ? HUNT : FILL;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_fill_nxt  = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Pattern capture, history shift, fill count and registered match pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pat   <= '0;
            r_mask  <= '0;
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else begin
            if (load_pattern) begin
                r_pat  <= pattern;
                r_mask <= mask;
                r_hist <= '0;
            end else if (w_beat) begin
                r_hist <= w_hist_shift;
            end
            r_fill  <= w_fill_nxt;
            r_match <= w_hit;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (w_hit),
        .i_clr   (clear_count),
        .o_count (match_count)
    );

    assign match = r_match;
    assign armed = (r_state == FILL) || (r_state == HUNT);

endmodule

// File: tb/tb_pattern_matcher_n.sv
// Directed table-driven bench for pattern_matcher_n, plus hand sequences for
// counter saturation/clear priority and reset in the middle of a stream.
module tb_pattern_matcher_n;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       data_in = 1'b0, input_valid = 1'b0;
    logic [7:0] pattern = '0, mask = '0;
    logic       load_pattern = 1'b0, overlap_en = 1'b0, clear_count = 1'b0;
    logic       match8, armed8, match2, armed2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pattern_matcher_n #(.PAT_W(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .data_in(data_in), .input_valid(input_valid),
        .pattern(pattern), .mask(mask), .load_pattern(load_pattern),
        .overlap_en(overlap_en), .clear_count(clear_count),
        .match(match8), .match_count(cnt8), .armed(armed8));

    pattern_matcher_n #(.PAT_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .data_in(data_in), .input_valid(input_valid),
        .pattern(pattern), .mask(mask), .load_pattern(load_pattern),
        .overlap_en(overlap_en), .clear_count(clear_count),
        .match(match2), .match_count(cnt2), .armed(armed2));

    typedef struct {
        string      nm;
        bit         ld;
        logic [7:0] pat;
        logic [7:0] msk;
        bit         ovl;
        bit         vld;
        bit         din;
        bit         clr;
        bit         em;
        int         ec;
        bit         ea;
    } vec_t;

    vec_t vecs[$];
    int   ecnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void add(input string nm, input bit ld, input logic [7:0] pat,
                                input logic [7:0] msk, input bit ovl, input bit vld,
                                input bit din, input bit clr, input bit em, input bit ea);
        vec_t v;
        if (clr) ecnt = 0;
        else if (em && ecnt < 255) ecnt++;
        v.nm = nm; v.ld = ld; v.pat = pat; v.msk = msk; v.ovl = ovl; v.vld = vld;
        v.din = din; v.clr = clr; v.em = em; v.ec = ecnt; v.ea = ea;
        vecs.push_back(v);
    endfunction

    function automatic void add_load(input string nm, input logic [7:0] pat,
                                     input logic [7:0] msk, input bit ovl, input bit din);
        add(nm, 1'b1, pat, msk, ovl, 1'b1, din, 1'b0, 1'b0, 1'b1);
    endfunction

    // Bits are sent MSB first (bit n-1 first); hits marks expected match rows.
    // Pattern/mask inputs carry junk to show they only matter on load.
    function automatic void add_bits(input string nm, input logic [15:0] bits, input int n,
                                     input bit ovl, input logic [15:0] hits);
        for (int i = 0; i < n; i++)
            add(nm, 1'b0, 8'h3C, 8'hC3, ovl, 1'b1, bits[n-1-i], 1'b0, hits[n-1-i], 1'b1);
    endfunction

    function automatic void add_gap(input string nm, input int n);
        for (int i = 0; i < n; i++)
            add(nm, 1'b0, 8'h3C, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    endfunction

    task automatic step(input bit ld, input logic [7:0] pat, input logic [7:0] msk,
                        input bit ovl, input bit vld, input bit din, input bit clr);
        load_pattern = ld; pattern = pat; mask = msk; overlap_en = ovl;
        input_valid = vld; data_in = din; clear_count = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Unarmed after reset: a zero mask would match anything if data leaked in.
        for (int i = 0; i < 9; i++)
            add("idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, i[0], 1'b0, 1'b0, 1'b0);
        add_load("a5_load", 8'hA5, 8'hFF, 1'b0, 1'b0);
        add_bits("a5", 16'h00A5, 8, 1'b0, 16'h0001);
        add_gap("a5_hold", 1);
        add_load("aa_ovl_load", 8'hAA, 8'hFF, 1'b1, 1'b0);
        add_bits("aa_ovl", 16'h02AA, 10, 1'b1, 16'h0005);
        add_load("aa_novl_load", 8'hAA, 8'hFF, 1'b0, 1'b0);
        add_bits("aa_novl", 16'h02AA, 10, 1'b0, 16'h0004);
        add("clr", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        add_load("mask_f0_load", 8'hA5, 8'hF0, 1'b0, 1'b0);
        add_bits("mask_f0", 16'h00A0, 8, 1'b0, 16'h0001);
        add_load("gap_load", 8'hA5, 8'hFF, 1'b0, 1'b0);
        add_bits("gap_hi", 16'h000A, 4, 1'b0, 16'h0000);
        add_gap("gap", 3);
        add_bits("gap_lo", 16'h0005, 4, 1'b0, 16'h0001);
        // Load beat carries a valid 1 that must be discarded.
        add_load("m0_load", 8'h00, 8'h00, 1'b1, 1'b1);
        add_bits("m0_ovl", 16'h01FF, 9, 1'b1, 16'h0003);
        add_bits("m0_to_novl", 16'h0001, 1, 1'b0, 16'h0001);
        add_bits("m0_novl", 16'h0001, 1, 1'b0, 16'h0000);

        // Reset state
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_match", match8, 0);
        chk("rst_count", cnt8, 0);
        chk("rst_armed", armed8, 0);
        chk("rst_count2", cnt2, 0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].ld, vecs[i].pat, vecs[i].msk, vecs[i].ovl,
                 vecs[i].vld, vecs[i].din, vecs[i].clr);
            chk({vecs[i].nm, "_match"}, match8, vecs[i].em);
            chk({vecs[i].nm, "_count"}, cnt8, vecs[i].ec);
            chk({vecs[i].nm, "_armed"}, armed8, vecs[i].ea);
        end

        // Saturation on the 2-bit counter and clear-beats-increment.
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        step(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("sat_prefill_match", match2, 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
            chk("sat_match", match2, 1);
            chk("sat_count2", cnt2, (i < 3) ? i + 1 : 3);
            chk("sat_count8", cnt8, i + 1);
        end
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_hit_match", match2, 1);
        chk("clr_hit_count2", cnt2, 0);
        chk("clr_hit_count8", cnt8, 0);

        // Reset after 5 bits of A5: partial sequence lost, stays unarmed.
        step(1'b1, 8'hA5, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] b;
            b = 8'hA5;
            step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, b[7-i], 1'b0);
        end
        chk("pre_rst_armed", armed8, 1);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_armed", armed8, 0);
        chk("async_rst_match", match8, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 5; i < 8; i++) begin
            logic [7:0] b;
            b = 8'hA5;
            step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, b[7-i], 1'b0);
            chk("post_rst_match", match8, 0);
            chk("post_rst_armed", armed8, 0);
        end
        step(1'b1, 8'hA5, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            b = 8'hA5;
            step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, b[7-i], 1'b0);
            chk("reload_match", match8, (i == 7) ? 1 : 0);
        end
        chk("reload_count", cnt8, 1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reload_pulse_end", match8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
